// File: rtl/key_event_gen_pkg.sv
// Shared key event codes and key-vector layout for the panel key front end.
package key_event_gen_pkg;

    localparam logic [2:0] KEY_NONE       = 3'd0;
    localparam logic [2:0] KEY_SET        = 3'd1;
    localparam logic [2:0] KEY_SHIFT      = 3'd2;
    localparam logic [2:0] KEY_MODE       = 3'd3;
    localparam logic [2:0] KEY_PLUS       = 3'd4;
    localparam logic [2:0] KEY_MINUS      = 3'd5;
    localparam logic [2:0] KEY_PLUS_HOLD  = 3'd6;
    localparam logic [2:0] KEY_MINUS_HOLD = 3'd7;

    localparam int unsigned NUM_KEYS = 5;

    // Bit order of every per-key vector: {mode, plus, minus, shift, set}
    typedef struct packed {
        logic mode;
        logic plus;
        logic minus;
        logic shift;
        logic set;
    } keys_t;

    localparam logic [NUM_KEYS-1:0] MASK_MODE  = 5'b10000;
    localparam logic [NUM_KEYS-1:0] MASK_PLUS  = 5'b01000;
    localparam logic [NUM_KEYS-1:0] MASK_MINUS = 5'b00100;
    localparam logic [NUM_KEYS-1:0] MASK_SHIFT = 5'b00010;
    localparam logic [NUM_KEYS-1:0] MASK_SET   = 5'b00001;

endpackage

// File: rtl/key_event_gen_debounce.sv
// One key: 2-FF synchroniser, tick-based debounce and registered press edge.
module key_debounce #(
    parameter int unsigned DEB_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic key_raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEB_TICKS + 1);

    logic          sync1;
    logic          sync2;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;

    // Debounce counter: counts ticks of disagreement, toggles on the DEB_TICKS-th one
    always_comb begin
        level_nxt = level;
        cnt_nxt   = cnt;
        if (sync2 == level) begin
            cnt_nxt = '0;
        end else if (tick) begin
            if (cnt == CW'(DEB_TICKS - 1)) begin
                level_nxt = ~level;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // A key held through reset is not reported until it has been seen released
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            level <= level_nxt;
            cnt   <= cnt_nxt;
            rise  <= level_nxt & ~level & armed;
            if (tick && !sync2 && !level) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// Panel key front end: debounces five keys and emits coded press/hold/repeat events.
module key_event_gen
    import key_event_gen_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 20000,
    parameter int unsigned DEB_TICKS    = 10,
    parameter int unsigned HOLD_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_plus,
    input  logic       key_minus,
    input  logic       key_shift,
    input  logic       key_set,
    output logic       key_valid,
    output logic [2:0] key_code,
    output logic       key_busy
);

    localparam int unsigned PW      = $clog2(TICK_DIV + 1);
    localparam int unsigned CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned HW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_REL = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_REPEAT   = 2'd3;

    logic [PW-1:0]       pcnt;
    logic                tick;
    logic [NUM_KEYS-1:0] raw;
    logic [NUM_KEYS-1:0] lvl;
    logic [NUM_KEYS-1:0] rise;
    keys_t               rise_s;

    logic [1:0]          state,   state_nxt;
    logic [NUM_KEYS-1:0] act,     act_nxt;
    logic [HW-1:0]       hcnt,    hcnt_nxt;
    logic                valid_nxt;
    logic [2:0]          code_nxt;
    logic                act_down;
    logic [2:0]          hold_code;

    assign raw    = {key_mode, key_plus, key_minus, key_shift, key_set};
    assign rise_s = keys_t'(rise);

    // Timebase prescaler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (pcnt == PW'(TICK_DIV - 1)) begin
            pcnt <= '0;
            tick <= 1'b1;
        end else begin
            pcnt <= pcnt + PW'(1);
            tick <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .key_raw (raw[i]),
            .level   (lvl[i]),
            .rise    (rise[i])
        );
    end

    assign act_down  = |(lvl & act);
    assign hold_code = (act == MASK_PLUS) ? KEY_PLUS_HOLD : KEY_MINUS_HOLD;

    // Event FSM; priority in IDLE is mode > shift > plus > minus > set
    always_comb begin
        state_nxt = state;
        act_nxt   = act;
        hcnt_nxt  = hcnt;
        valid_nxt = 1'b0;
        code_nxt  = key_code;
        case (state)
            ST_IDLE: begin
                if (rise_s.mode) begin
                    valid_nxt = 1'b1;
                    code_nxt  = KEY_MODE;
                    act_nxt   = MASK_MODE;
                    state_nxt = ST_WAIT_REL;
                end else if (rise_s.shift) begin
                    valid_nxt = 1'b1;
                    code_nxt  = KEY_SHIFT;
                    act_nxt   = MASK_SHIFT;
                    state_nxt = ST_WAIT_REL;
                end else if (rise_s.plus) begin
                    valid_nxt = 1'b1;
                    code_nxt  = KEY_PLUS;
                    act_nxt   = MASK_PLUS;
                    hcnt_nxt  = '0;
                    state_nxt = ST_HOLD;
                end else if (rise_s.minus) begin
                    valid_nxt = 1'b1;
                    code_nxt  = KEY_MINUS;
                    act_nxt   = MASK_MINUS;
                    hcnt_nxt  = '0;
                    state_nxt = ST_HOLD;
                end else if (rise_s.set) begin
                    valid_nxt = 1'b1;
                    code_nxt  = KEY_SET;
                    act_nxt   = MASK_SET;
                    state_nxt = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (!act_down) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!act_down) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    if (hcnt == HW'(HOLD_TICKS - 1)) begin
                        valid_nxt = 1'b1;
                        code_nxt  = hold_code;
                        hcnt_nxt  = '0;
                        state_nxt = ST_REPEAT;
                    end else begin
                        hcnt_nxt = hcnt + HW'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (!act_down) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    if (hcnt == HW'(REPEAT_TICKS - 1)) begin
                        valid_nxt = 1'b1;
                        code_nxt  = hold_code;
                        hcnt_nxt  = '0;
                    end else begin
                        hcnt_nxt = hcnt + HW'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            act       <= '0;
            hcnt      <= '0;
            key_valid <= 1'b0;
            key_code  <= KEY_NONE;
            key_busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            act       <= act_nxt;
            hcnt      <= hcnt_nxt;
            key_valid <= valid_nxt;
            key_code  <= code_nxt;
            key_busy  <= |lvl;
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Randomised and directed bench for key_event_gen against an event-level reference model.
module tb_key_event_gen;

    localparam int TD   = 4;
    localparam int DEB  = 3;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    localparam int K_MODE  = 4;
    localparam int K_PLUS  = 3;
    localparam int K_MINUS = 2;
    localparam int K_SHIFT = 1;
    localparam int K_SET   = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] keys = 5'b0;
    logic       key_valid;
    logic [2:0] key_code;
    logic       key_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    key_event_gen #(
        .TICK_DIV     (TD),
        .DEB_TICKS    (DEB),
        .HOLD_TICKS   (HOLD),
        .REPEAT_TICKS (REP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_mode  (keys[K_MODE]),
        .key_plus  (keys[K_PLUS]),
        .key_minus (keys[K_MINUS]),
        .key_shift (keys[K_SHIFT]),
        .key_set   (keys[K_SET]),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_busy  (key_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (tick-count deadlines, merged hold/repeat phase) -------------
    int prio_key[5]  = '{K_MODE, K_SHIFT, K_PLUS, K_MINUS, K_SET};
    int prio_code[5] = '{3, 2, 4, 5, 1};

    bit m_s1[5], m_s2[5], m_lvl[5], m_armed[5], m_rise[5];
    int m_mark[5];
    int m_edges, m_gticks, m_deadline, m_act, m_phase;   // phase: 0 idle, 1 wait release, 2 holding
    bit m_tick, m_valid, m_busy;
    int m_code;

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_armed[k] = 0; m_rise[k] = 0; m_mark[k] = 0;
        end
        m_edges = 0; m_gticks = 0; m_deadline = 0; m_act = 0; m_phase = 0;
        m_tick = 0; m_valid = 0; m_busy = 0; m_code = 0;
    endtask

    task automatic model_step();
        bit t;
        bit found;
        bit r;
        bit lvl_old[5];
        t = m_tick;
        m_edges++;
        if (t) m_gticks++;
        lvl_old = m_lvl;
        m_busy = 0;
        for (int k = 0; k < 5; k++) if (lvl_old[k]) m_busy = 1;
        m_valid = 0;
        if (m_phase == 0) begin
            found = 0;
            for (int i = 0; i < 5; i++) begin
                if (!found && m_rise[prio_key[i]]) begin
                    found    = 1;
                    m_valid  = 1;
                    m_code   = prio_code[i];
                    m_act    = prio_key[i];
                    m_phase  = (m_act == K_PLUS || m_act == K_MINUS) ? 2 : 1;
                    m_deadline = m_gticks + HOLD;
                end
            end
        end else if (!lvl_old[m_act]) begin
            m_phase = 0;
        end else if (m_phase == 2 && t && m_gticks == m_deadline) begin
            m_valid    = 1;
            m_code     = (m_act == K_PLUS) ? 6 : 7;
            m_deadline = m_gticks + REP;
        end
        for (int k = 0; k < 5; k++) begin
            r = 0;
            if (m_s2[k] != lvl_old[k]) begin
                if (t && (m_gticks - m_mark[k]) == DEB) begin
                    m_lvl[k]  = !lvl_old[k];
                    m_mark[k] = m_gticks;
                    r = m_lvl[k] && m_armed[k];
                end
            end else begin
                m_mark[k] = m_gticks;
            end
            if (t && !m_s2[k] && !lvl_old[k]) m_armed[k] = 1;
            m_rise[k] = r;
            m_s2[k] = m_s1[k];
            m_s1[k] = keys[k];
        end
        m_tick = (m_edges % TD == 0);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(posedge clk) cyc++;

    // ---------------- per-cycle compare and event log ----------------
    int ev_code[$];
    int ev_cyc[$];
    bit busy_seen = 0;

    always @(negedge clk) begin
        check("valid", key_valid, m_valid);
        check("code",  key_code,  m_code);
        check("busy",  key_busy,  m_busy);
        if (key_valid === 1'b1) begin
            ev_code.push_back(int'(key_code));
            ev_cyc.push_back(cyc);
        end
        if (key_busy === 1'b1) busy_seen = 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        ev_code.delete();
        ev_cyc.delete();
        busy_seen = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int n7;
        @(negedge clk);
        check("reset_valid", key_valid, 0);
        check("reset_code",  key_code,  0);
        check("reset_busy",  key_busy,  0);
        idle(2);
        reset = 1'b0;
        idle(20);

        // Glitch of 2 ticks never reaches the debounced level
        clear_log();
        keys[K_PLUS] = 1'b1; idle(8);
        keys[K_PLUS] = 1'b0; idle(40);
        check("t2_events", ev_code.size(), 0);
        check("t2_code", key_code, 0);

        // Single set press
        clear_log();
        keys[K_SET] = 1'b1; idle(40);
        keys[K_SET] = 1'b0; idle(40);
        check("t1_events", ev_code.size(), 1);
        if (ev_code.size() > 0) check("t1_code", ev_code[0], 1);
        check("t1_busy_seen", busy_seen, 1);
        check("t1_code_held", key_code, 1);

        // Simultaneous mode + set: mode wins, set discarded
        clear_log();
        keys[K_MODE] = 1'b1; keys[K_SET] = 1'b1; idle(40);
        keys = 5'b0; idle(40);
        check("t3_events", ev_code.size(), 1);
        if (ev_code.size() > 0) check("t3_code", ev_code[0], 3);

        // Minus hold with auto-repeat
        clear_log();
        keys[K_MINUS] = 1'b1; idle(200);
        keys[K_MINUS] = 1'b0; idle(40);
        n7 = 0;
        for (int i = 1; i < ev_code.size(); i++) if (ev_code[i] == 7) n7++;
        check("t4_first_code", (ev_code.size() > 0) ? ev_code[0] : -1, 5);
        check("t4_all_repeats_are_7", n7, ev_code.size() - 1);
        check("t4_repeat_count_in_6_to_7", (n7 >= 6 && n7 <= 7), 1);
        if (ev_code.size() > 1) begin
            gap = ev_cyc[1] - ev_cyc[0];
            check("t4_first_hold_gap_77_to_80", (gap >= 77 && gap <= 80), 1);
        end
        for (int i = 2; i < ev_code.size(); i++) check("t4_repeat_gap", ev_cyc[i] - ev_cyc[i-1], 20);

        // Shift held, plus pressed meanwhile: only shift reported
        clear_log();
        keys[K_SHIFT] = 1'b1; idle(30);
        keys[K_PLUS]  = 1'b1; idle(40);
        keys[K_SHIFT] = 1'b0; idle(40);
        check("t5_events_before_repress", ev_code.size(), 1);
        if (ev_code.size() > 0) check("t5_code", ev_code[0], 2);
        keys[K_PLUS] = 1'b0; idle(30);
        keys[K_PLUS] = 1'b1; idle(30);
        keys[K_PLUS] = 1'b0; idle(40);
        check("t5_events_after_repress", ev_code.size(), 2);
        if (ev_code.size() > 1) check("t5_repress_code", ev_code[1], 4);

        // Reset during minus repeat
        keys[K_MINUS] = 1'b1; idle(140);
        #2 reset = 1'b1;
        #1;
        check("t6_reset_valid", key_valid, 0);
        check("t6_reset_code",  key_code,  0);
        check("t6_reset_busy",  key_busy,  0);
        clear_log();
        idle(3);
        reset = 1'b0;
        idle(100);
        check("t6_no_event_while_held", ev_code.size(), 0);
        keys[K_MINUS] = 1'b0; idle(40);
        check("t6_no_event_on_release", ev_code.size(), 0);
        keys[K_MINUS] = 1'b1; idle(30);
        keys[K_MINUS] = 1'b0; idle(40);
        check("t6_repress_events", ev_code.size(), 1);
        if (ev_code.size() > 0) check("t6_repress_code", ev_code[0], 5);

        // Randomised key activity, checked cycle by cycle against the model
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
                @(negedge clk);
            end
            for (int k = 0; k < 5; k++) keys[k] = ($urandom_range(0, 2) == 0);
            idle($urandom_range(1, 60));
        end
        keys = 5'b0;
        idle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Upstream front end for the operator-panel interface.
- Conditions the five raw panel keys: mode, plus, minus, shift and set.
- Synchronises, debounces, edge-detects and priority-encodes them.
- Generates hold and auto-repeat events for plus and minus.
- Delivers single-cycle coded key events to the menu/state-control logic, replacing ad-hoc key scanning there.

Parameters:
- TICK_DIV, 20000: clk cycles per internal timebase tick (1 kHz at 20 MHz).
- DEB_TICKS, 10: consecutive ticks a key must be stable before its debounced level changes.
- HOLD_TICKS, 1000: ticks plus/minus must stay pressed before the first hold event.
- REPEAT_TICKS, 100: ticks between repeated hold events while still pressed.

Ports:
- clk  in  1  system clock, 20 MHz.
- reset  in  1  asynchronous, active-high reset.
- key_mode  in  1  raw key, high = pressed, asynchronous to clk.
- key_plus  in  1  raw key, high = pressed, asynchronous to clk.
- key_minus  in  1  raw key, high = pressed, asynchronous to clk.
- key_shift  in  1  raw key, high = pressed, asynchronous to clk.
- key_set  in  1  raw key, high = pressed, asynchronous to clk.
- key_valid  out  1  one-cycle pulse per key event.
- key_code  out  3  event code; 0 none, 1 set, 2 shift, 3 mode, 4 plus, 5 minus, 6 plus_hold, 7 minus_hold.
- key_busy  out  1  high while any debounced key is down.

Behaviour:
- Reset values (asynchronous, active-high reset): key_valid=0, key_code=0, key_busy=0. Synchronisers, debounced levels, tick prescaler, hold counter and FSM all clear; FSM goes to IDLE.
- Reset asserted mid-press: all state clears. A key still held after reset deasserts produces no event until it is released and pressed again.
- Synchronisation: each raw key passes through a 2-FF synchroniser.
- Tick: prescaler counts 0..TICK_DIV-1 and pulses tick for one clk on wrap.
- Debounce, per key:
  - The counter increments on tick while the synced level differs from the debounced level.
  - It clears whenever the levels are equal.
  - On reaching DEB_TICKS the debounced level toggles and the counter clears.
  - Glitches shorter than DEB_TICKS ticks never reach the debounced level.
- Press edge: debounced level 0->1, registered. key_valid rises on the clk after the debounced level rises.
- Priority when press edges occur in the same cycle: mode > shift > plus > minus > set. Only the winner is reported; losers are discarded, not queued.
- key_code holds its last value between events. key_busy = OR of the debounced levels, registered.
- FSM:
  - IDLE:
    - A winning press edge emits its code (3/2/4/5/1).
    - set, shift or mode -> WAIT_REL.
    - plus or minus -> HOLD, with the hold counter cleared.
  - WAIT_REL: ignore all new edges; when the active key's debounced level falls -> IDLE.
  - HOLD:
    - The counter increments on tick while the active key stays down.
    - At HOLD_TICKS: emit 6 (plus) or 7 (minus), clear the counter, -> REPEAT.
    - Active key release -> IDLE with no event.
  - REPEAT:
    - Every REPEAT_TICKS ticks, emit 6/7 again.
    - Release -> IDLE.
    - No limit on the repeat count.
- Other keys pressed while not in IDLE produce no event. A key still down when the FSM returns to IDLE needs a fresh edge to report.
- Release of the active key and a tick on the same cycle: release wins, no event.
- Counter widths: $clog2(param+1). Counters saturate-free by construction, since they clear on terminal count.

Decomposition:
- Key code constants (KEY_NONE..KEY_MINUS_HOLD) go in the shared defines.v alongside the existing display/state defines. The interface consumes the same codes.
- Sub-module key_debounce: synchroniser + debounce counter + registered rise-edge output, parameterised by DEB_TICKS, with tick as an input. Instantiate it five times.
- The prescaler, priority encoder and FSM stay in the top level.

Test Plan (TICK_DIV=4, DEB_TICKS=3, HOLD_TICKS=20, REPEAT_TICKS=5):
1. key_set high for 40 clk, then low -> exactly one key_valid pulse with key_code=1; no further event; key_busy high during the debounced window.
2. key_plus glitch high for 8 clk (2 ticks) -> no key_valid; key_code stays 0.
3. key_mode and key_set asserted on the same clk, held 40 clk -> one event, code 3; releasing both gives nothing more.
4. key_minus held 200 clk:
   - code 5 first.
   - Code 7 about 80 clk (20 ticks) later.
   - Code 7 every 20 clk (5 ticks) thereafter.
   - Release stops events.
5. Hold key_shift, then press key_plus while shift is down -> only code 2. Release shift with plus still down -> no event until plus is re-pressed.
6. Assert reset during a minus REPEAT phase -> outputs 0 immediately. Minus still held after reset deasserts -> no event until it is released and re-pressed.
